// File: rtl/div_reconstruct.sv
// Shift-add reconstruction of a dividend from a {rem, quot} divider result word.
// Optional range check on the result word is enabled by defining DIV_RECON_CHECK_EN.
module div_reconstruct (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rslt,
  input  logic [3:0] b,
  output logic [7:0] a,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  quot_q, quot_d;
  logic [3:0]  b_q, b_d;
  logic        accept;

  assign accept = (state_q == S_IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred latches.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt_q == 2'd3) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_CALC:  busy = 1'b1;
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: quotient consumed LSB first, shifted divisor added per set bit
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    b_d    = b_q;
    if (accept) begin
      acc_d  = {4'b0, rslt[7:4]};
      cnt_d  = 2'd0;
      quot_d = rslt[3:0];
      b_d    = b;
    end else if (state_q == S_CALC) begin
      if (quot_q[cnt_q]) acc_d = acc_q + ({4'b0, b_q} << cnt_q);
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 8'd0;
      cnt_q <= 2'd0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: captured operands are always reloaded at accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    quot_q <= quot_d;
    b_q    <= b_d;
  end

  assign a = acc_q;

`ifdef DIV_RECON_CHECK_EN
  logic err_q;

  // A valid division always leaves rem < b with a non-zero divisor
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= (b == 4'd0) || (rslt[7:4] >= b);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
